// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch path.
package otter_pkg;

    // Next-PC select encoding driven by the control FSM
    typedef enum logic [2:0] {
        PCSRC_PLUS4  = 3'd0,
        PCSRC_JALR   = 3'd1,
        PCSRC_BRANCH = 3'd2,
        PCSRC_JAL    = 3'd3,
        PCSRC_MTVEC  = 3'd4,
        PCSRC_MEPC   = 3'd5
    } pc_src_t;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        REQ   = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // True when an instruction address is not word aligned
    function automatic logic addr_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/otter_pc_mux.sv
// Combinational next-PC selection with alignment check on jump/branch targets.
module otter_pc_mux
    import otter_pkg::*;
#(
    parameter int PCSRC_W = 3
) (
    input  logic [PCSRC_W-1:0] i_sel,
    input  logic [31:0]        i_pc_plus4,
    input  logic [31:0]        i_jalr,
    input  logic [31:0]        i_branch,
    input  logic [31:0]        i_jal,
    input  logic [31:0]        i_mtvec,
    input  logic [31:0]        i_mepc,
    output logic [31:0]        o_next_pc,
    output logic               o_misalign
);

    // Select the target; only JALR/BRANCH/JAL targets are alignment checked
    always_comb begin
        o_next_pc  = i_pc_plus4;
        o_misalign = 1'b0;
        case (i_sel)
            PCSRC_JALR: begin
                o_next_pc  = i_jalr;
                o_misalign = addr_misaligned(i_jalr);
            end
            PCSRC_BRANCH: begin
                o_next_pc  = i_branch;
                o_misalign = addr_misaligned(i_branch);
            end
            PCSRC_JAL: begin
                o_next_pc  = i_jal;
                o_misalign = addr_misaligned(i_jal);
            end
            PCSRC_MTVEC: o_next_pc = i_mtvec;
            PCSRC_MEPC:  o_next_pc = i_mepc;
            default: begin
                // PC+4 and the reserved encodings
                o_next_pc  = i_pc_plus4;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/otter_fetch_unit.sv
// Owns the architectural PC, sequences instruction fetches and holds IR for decode.
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          PCSRC_W      = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [PCSRC_W-1:0] PC_SOURCE,
    input  logic [31:0]        JALR,
    input  logic [31:0]        BRANCH,
    input  logic [31:0]        JAL,
    input  logic [31:0]        MTVEC,
    input  logic [31:0]        MEPC,
    input  logic               FLUSH,
    output logic               IMEM_REQ,
    output logic [31:0]        IMEM_ADDR,
    input  logic               IMEM_GNT,
    input  logic               IMEM_RVALID,
    input  logic [31:0]        IMEM_RDATA,
    output logic [31:0]        IR,
    output logic               IR_VALID,
    input  logic               IR_READY,
    output logic [31:0]        PC,
    output logic [31:0]        PC_PLUS4,
    output logic               MISALIGN
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic         r_ir_valid;
    logic         r_misalign;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic         w_target_misaligned;
    logic         w_pc_load;
    logic         w_ir_load;
    logic         w_ir_valid_next;
    logic         w_misalign_next;

    assign w_pc_plus4 = r_pc + 32'd4;

    otter_pc_mux #(
        .PCSRC_W (PCSRC_W)
    ) u_pc_mux (
        .i_sel      (PC_SOURCE),
        .i_pc_plus4 (w_pc_plus4),
        .i_jalr     (JALR),
        .i_branch   (BRANCH),
        .i_jal      (JAL),
        .i_mtvec    (MTVEC),
        .i_mepc     (MEPC),
        .o_next_pc  (w_target),
        .o_misalign (w_target_misaligned)
    );

    // Next-state and register-update decisions; FLUSH overrides every state
    always_comb begin
        w_next_state    = r_state;
        w_pc_load       = 1'b0;
        w_ir_load       = 1'b0;
        w_ir_valid_next = r_ir_valid;
        w_misalign_next = 1'b0;
        if (FLUSH) begin
            w_pc_load       = 1'b1;
            w_ir_valid_next = 1'b0;
            // A grant in the same cycle still leaves a response outstanding
            if ((r_state == WAIT) || ((r_state == REQ) && IMEM_GNT)) begin
                w_next_state = DRAIN;
            end else begin
                w_next_state = REQ;
            end
        end else begin
            case (r_state)
                REQ: begin
                    if (IMEM_GNT) begin
                        w_next_state = WAIT;
                    end else begin
                        w_next_state = REQ;
                    end
                end
                WAIT: begin
                    if (IMEM_RVALID) begin
                        w_ir_load       = 1'b1;
                        w_ir_valid_next = 1'b1;
                        w_next_state    = HOLD;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
                HOLD: begin
                    if (IR_READY) begin
                        w_ir_valid_next = 1'b0;
                        if (w_target_misaligned) begin
                            w_misalign_next = 1'b1;
                            w_next_state    = FAULT;
                        end else begin
                            w_pc_load    = 1'b1;
                            w_next_state = REQ;
                        end
                    end else begin
                        w_next_state = HOLD;
                    end
                end
                DRAIN: begin
                    if (IMEM_RVALID) begin
                        w_next_state = REQ;
                    end else begin
                        w_next_state = DRAIN;
                    end
                end
                FAULT: begin
                    w_ir_valid_next = 1'b0;
                    w_next_state    = FAULT;
                end
                default: begin
                    w_ir_valid_next = 1'b0;
                    w_next_state    = REQ;
                end
            endcase
        end
    end

    // State, PC, IR and status registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= REQ;
            r_pc       <= RESET_VECTOR;
            r_ir       <= 32'h0000_0000;
            r_ir_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ir_valid <= w_ir_valid_next;
            r_misalign <= w_misalign_next;
            if (w_pc_load) begin
                r_pc <= w_target;
            end
            if (w_ir_load) begin
                r_ir <= IMEM_RDATA;
            end
        end
    end

    // Request is suppressed while reset is asserted so nothing leaks out during reset
    assign IMEM_REQ  = (r_state == REQ) && !RST;
    assign IMEM_ADDR = r_pc;
    assign PC        = r_pc;
    assign PC_PLUS4  = w_pc_plus4;
    assign IR        = r_ir;
    assign IR_VALID  = r_ir_valid;
    assign MISALIGN  = r_misalign;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed self-checking bench for otter_fetch_unit.
module tb_otter_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [2:0]  PC_SOURCE;
    logic [31:0] JALR;
    logic [31:0] BRANCH;
    logic [31:0] JAL;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;
    logic        FLUSH;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic [31:0] IR;
    logic        IR_VALID;
    logic        IR_READY;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        MISALIGN;

    int n_vec;
    int n_bad;

    otter_fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_SOURCE   (PC_SOURCE),
        .JALR        (JALR),
        .BRANCH      (BRANCH),
        .JAL         (JAL),
        .MTVEC       (MTVEC),
        .MEPC        (MEPC),
        .FLUSH       (FLUSH),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .IR          (IR),
        .IR_VALID    (IR_VALID),
        .IR_READY    (IR_READY),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .MISALIGN    (MISALIGN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant in the current REQ cycle, return data the following cycle
    task automatic fetch(input logic [31:0] data);
        IMEM_GNT = 1'b1;
        tick();
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = data;
        tick();
        IMEM_RVALID = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        RST = 1'b1; PC_SOURCE = 3'd0; JALR = 32'h0; BRANCH = 32'h0; JAL = 32'h0;
        MTVEC = 32'h0; MEPC = 32'h0; FLUSH = 1'b0; IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0; IR_READY = 1'b0;
        tick();
        tick();
        chk("rst_req",      {31'h0, IMEM_REQ}, 32'h0);
        chk("rst_ir_valid", {31'h0, IR_VALID}, 32'h0);
        chk("rst_misalign", {31'h0, MISALIGN}, 32'h0);
        chk("rst_pc",       PC, 32'h0);
        chk("rst_ir",       IR, 32'h0);

        // First fetch right after release: GNT same cycle, RVALID next
        RST = 1'b0;
        #1;
        chk("first_req",   {31'h0, IMEM_REQ}, 32'h1);
        chk("first_addr",  IMEM_ADDR, 32'h0);
        chk("first_plus4", PC_PLUS4, 32'h4);
        IMEM_GNT = 1'b1;
        tick();
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h0000_0013;
        chk("wait_req",      {31'h0, IMEM_REQ}, 32'h0);
        chk("wait_ir_valid", {31'h0, IR_VALID}, 32'h0);
        tick();
        IMEM_RVALID = 1'b0;
        chk("first_ir",       IR, 32'h0000_0013);
        chk("first_ir_valid", {31'h0, IR_VALID}, 32'h1);

        // IR_READY with JAL target 0x100
        PC_SOURCE = 3'd3; JAL = 32'h0000_0100; IR_READY = 1'b1;
        tick();
        IR_READY = 1'b0;
        chk("jal_req",      {31'h0, IMEM_REQ}, 32'h1);
        chk("jal_addr",     IMEM_ADDR, 32'h0000_0100);
        chk("jal_ir_valid", {31'h0, IR_VALID}, 32'h0);

        // Jump to the top word, then PC+4 wraps to zero
        fetch(32'h0000_0093);
        chk("second_ir", IR, 32'h0000_0093);
        JAL = 32'hFFFF_FFFC; IR_READY = 1'b1;
        tick();
        IR_READY = 1'b0;
        chk("top_addr",  IMEM_ADDR, 32'hFFFF_FFFC);
        chk("top_plus4", PC_PLUS4, 32'h0000_0000);
        fetch(32'h0000_0013);
        PC_SOURCE = 3'd0; IR_READY = 1'b1;
        tick();
        IR_READY = 1'b0;
        chk("wrap_req",  {31'h0, IMEM_REQ}, 32'h1);
        chk("wrap_addr", IMEM_ADDR, 32'h0000_0000);

        // Misaligned JALR: one-cycle MISALIGN, PC kept, fetch stops
        fetch(32'h0000_0013);
        PC_SOURCE = 3'd1; JALR = 32'h0000_0102; IR_READY = 1'b1;
        tick();
        IR_READY = 1'b0;
        chk("mis_pulse",    {31'h0, MISALIGN}, 32'h1);
        chk("mis_pc",       PC, 32'h0000_0000);
        chk("mis_req",      {31'h0, IMEM_REQ}, 32'h0);
        chk("mis_ir_valid", {31'h0, IR_VALID}, 32'h0);
        tick();
        chk("mis_one_cycle", {31'h0, MISALIGN}, 32'h0);
        chk("fault_req",     {31'h0, IMEM_REQ}, 32'h0);
        chk("fault_pc",      PC, 32'h0000_0000);
        FLUSH = 1'b1; PC_SOURCE = 3'd4; MTVEC = 32'h0000_0200;
        tick();
        FLUSH = 1'b0;
        chk("trap_req",  {31'h0, IMEM_REQ}, 32'h1);
        chk("trap_addr", IMEM_ADDR, 32'h0000_0200);

        // FLUSH in WAIT: the outstanding word is discarded
        IMEM_GNT = 1'b1;
        tick();
        IMEM_GNT = 1'b0;
        FLUSH = 1'b1; PC_SOURCE = 3'd5; MEPC = 32'h0000_0040;
        tick();
        FLUSH = 1'b0;
        chk("drain_req", {31'h0, IMEM_REQ}, 32'h0);
        chk("drain_pc",  PC, 32'h0000_0040);
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
        tick();
        IMEM_RVALID = 1'b0;
        chk("drain_ir_valid", {31'h0, IR_VALID}, 32'h0);
        chk("drain_ir",       IR, 32'h0000_0013);
        chk("mret_req",       {31'h0, IMEM_REQ}, 32'h1);
        chk("mret_addr",      IMEM_ADDR, 32'h0000_0040);
        fetch(32'h0BAD_C0DE);
        chk("mret_ir",       IR, 32'h0BAD_C0DE);
        chk("mret_ir_valid", {31'h0, IR_VALID}, 32'h1);

        // FLUSH together with IR_READY: FLUSH wins
        PC_SOURCE = 3'd4; JAL = 32'h0000_0800; IR_READY = 1'b1; FLUSH = 1'b1;
        tick();
        IR_READY = 1'b0; FLUSH = 1'b0;
        chk("flush_wins_addr", IMEM_ADDR, 32'h0000_0200);
        chk("flush_wins_req",  {31'h0, IMEM_REQ}, 32'h1);

        // Grant withheld for five cycles: request and address hold
        for (int i = 0; i < 5; i++) begin
            IR_READY = 1'b1;
            PC_SOURCE = 3'd3;
            tick();
            chk("stall_req",  {31'h0, IMEM_REQ}, 32'h1);
            chk("stall_addr", IMEM_ADDR, 32'h0000_0200);
        end
        IR_READY = 1'b0;

        // Reset in WAIT, late RVALID afterwards is ignored
        IMEM_GNT = 1'b1;
        tick();
        IMEM_GNT = 1'b0;
        RST = 1'b1;
        tick();
        chk("rst_wait_req", {31'h0, IMEM_REQ}, 32'h0);
        chk("rst_wait_pc",  PC, 32'h0000_0000);
        RST = 1'b0;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hFFFF_FFFF;
        tick();
        IMEM_RVALID = 1'b0;
        chk("stale_ir_valid", {31'h0, IR_VALID}, 32'h0);
        chk("stale_ir",       IR, 32'h0000_0000);
        chk("restart_req",    {31'h0, IMEM_REQ}, 32'h1);
        chk("restart_addr",   IMEM_ADDR, 32'h0000_0000);
        fetch(32'h0000_0013);
        chk("restart_ir",       IR, 32'h0000_0013);
        chk("restart_ir_valid", {31'h0, IR_VALID}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
